// File: rtl/reg_file_sb.sv
// ID-stage register file (32 x 32, 2R/1W) with an integrated load scoreboard
// that stalls ID while a source register still waits on an in-flight load.
module reg_file_sb #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_en_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   input  logic                  read_en_2,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   input  logic                  id_issue,
   input  logic                  id_write_en,
   input  logic [ADDR_WIDTH-1:0] id_write_addr,
   input  logic                  id_is_load,
   input  logic                  wb_write_en,
   input  logic [ADDR_WIDTH-1:0] wb_write_addr,
   input  logic [DATA_WIDTH-1:0] wb_write_data,
   input  logic                  wb_is_load,
   output logic                  load_stall,
   output logic                  sb_error
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [CNT_WIDTH-1:0]  pend [NUM_REGS];

   logic                  stall_1;
   logic                  stall_2;
   logic                  issue_ok;
   logic                  inc;
   logic                  dec;
   logic [NUM_REGS-1:0]   inc_vec;
   logic [NUM_REGS-1:0]   dec_vec;
   logic [NUM_REGS-1:0]   full_vec;
   logic [NUM_REGS-1:0]   empty_vec;
   logic                  err_set;

   // Register array: r0 is never written so it reads back as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_write_en && (wb_write_addr != '0)) begin
         regs[wb_write_addr] <= wb_write_data;
      end
   end

   // Read port 1: enable gate, r0 forced zero, write-first bypass from WB.
   always_comb begin
      read_data_1 = '0;
      if (rst || !read_en_1 || (read_addr_1 == '0)) begin
         read_data_1 = '0;
      end else if (wb_write_en && (wb_write_addr == read_addr_1)) begin
         read_data_1 = wb_write_data;
      end else begin
         read_data_1 = regs[read_addr_1];
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      read_data_2 = '0;
      if (rst || !read_en_2 || (read_addr_2 == '0)) begin
         read_data_2 = '0;
      end else if (wb_write_en && (wb_write_addr == read_addr_2)) begin
         read_data_2 = wb_write_data;
      end else begin
         read_data_2 = regs[read_addr_2];
      end
   end

   // Scoreboard decrement: a load retiring to a real register.
   always_comb begin
      dec = wb_write_en && wb_is_load && (wb_write_addr != '0);
   end

   // Per-port stall; the last pending load writing back this cycle is bypassed instead.
   always_comb begin
      stall_1 = read_en_1 && (read_addr_1 != '0) && (pend[read_addr_1] != '0) &&
                !(dec && (wb_write_addr == read_addr_1) && (pend[read_addr_1] == CNT_ONE));
      stall_2 = read_en_2 && (read_addr_2 != '0) && (pend[read_addr_2] != '0) &&
                !(dec && (wb_write_addr == read_addr_2) && (pend[read_addr_2] == CNT_ONE));
      load_stall = !rst && (stall_1 || stall_2);
   end

   // Scoreboard increment: only a load that actually leaves ID counts.
   always_comb begin
      issue_ok = id_issue && !load_stall;
      inc      = issue_ok && id_write_en && id_is_load && (id_write_addr != '0);
   end

   // One-hot update masks and counter saturation flags per register.
   always_comb begin
      inc_vec   = '0;
      dec_vec   = '0;
      full_vec  = '0;
      empty_vec = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         inc_vec[i]   = inc && (id_write_addr == ADDR_WIDTH'(i));
         dec_vec[i]   = dec && (wb_write_addr == ADDR_WIDTH'(i));
         full_vec[i]  = (pend[i] == CNT_MAX);
         empty_vec[i] = (pend[i] == '0);
      end
      err_set = (|(inc_vec & ~dec_vec & full_vec)) || (|(dec_vec & ~inc_vec & empty_vec));
   end

   // Pending-load counters; overflow/underflow hold the counter and flag an error.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (inc_vec[i] && !dec_vec[i] && !full_vec[i]) begin
               pend[i] <= pend[i] + CNT_ONE;
            end else if (dec_vec[i] && !inc_vec[i] && !empty_vec[i]) begin
               pend[i] <= pend[i] - CNT_ONE;
            end
         end
      end
   end

   // Sticky protocol-violation flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_error <= 1'b0;
      end else if (err_set) begin
         sb_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: expected outputs are queued as stimulus
// is driven and popped/compared once the combinational outputs have settled.
module tb_reg_file_sb;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   localparam int unsigned SEL_RD1   = 0;
   localparam int unsigned SEL_RD2   = 1;
   localparam int unsigned SEL_STALL = 2;
   localparam int unsigned SEL_ERR   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          read_en_1, read_en_2;
   logic [AW-1:0] read_addr_1, read_addr_2;
   logic [DW-1:0] read_data_1, read_data_2;
   logic          id_issue, id_write_en, id_is_load;
   logic [AW-1:0] id_write_addr;
   logic          wb_write_en, wb_is_load;
   logic [AW-1:0] wb_write_addr;
   logic [DW-1:0] wb_write_data;
   logic          load_stall, sb_error;

   typedef struct {
      string       tag;
      int unsigned sel;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [DW-1:0] mdl [32];

   reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut (
      .clk(clk), .rst(rst),
      .read_en_1(read_en_1), .read_addr_1(read_addr_1),
      .read_en_2(read_en_2), .read_addr_2(read_addr_2),
      .read_data_1(read_data_1), .read_data_2(read_data_2),
      .id_issue(id_issue), .id_write_en(id_write_en),
      .id_write_addr(id_write_addr), .id_is_load(id_is_load),
      .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr),
      .wb_write_data(wb_write_data), .wb_is_load(wb_is_load),
      .load_stall(load_stall), .sb_error(sb_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int unsigned sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      exp_q.push_back(e);
   endtask

   // Let inputs settle, then pop every queued expectation against the outputs.
   task automatic drain();
      exp_t        e;
      logic [31:0] got;
      #2;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.sel)
            SEL_RD1:   got = read_data_1;
            SEL_RD2:   got = read_data_2;
            SEL_STALL: got = 32'(load_stall);
            default:   got = 32'(sb_error);
         endcase
         check(e.tag, got, e.val);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      read_en_1 = 1'b0; read_addr_1 = '0;
      read_en_2 = 1'b0; read_addr_2 = '0;
      id_issue = 1'b0; id_write_en = 1'b0; id_is_load = 1'b0; id_write_addr = '0;
      wb_write_en = 1'b0; wb_is_load = 1'b0; wb_write_addr = '0; wb_write_data = '0;
   endtask

   task automatic issue_load(input logic [AW-1:0] a);
      id_issue = 1'b1; id_write_en = 1'b1; id_is_load = 1'b1; id_write_addr = a;
   endtask

   task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ld);
      wb_write_en = 1'b1; wb_write_addr = a; wb_write_data = d; wb_is_load = ld;
   endtask

   task automatic rd1(input logic [AW-1:0] a);
      read_en_1 = 1'b1; read_addr_1 = a;
   endtask

   task automatic rd2(input logic [AW-1:0] a);
      read_en_2 = 1'b1; read_addr_2 = a;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      // Outputs are forced quiet while reset is held, whatever the inputs.
      rd1(5'd5); rd2(5'd6); wb(5'd5, 32'hDEAD_BEEF, 1'b1);
      expect_out("rst_rd1", SEL_RD1, 32'h0);
      expect_out("rst_rd2", SEL_RD2, 32'h0);
      expect_out("rst_stall", SEL_STALL, 32'h0);
      drain();
      cyc();
      cyc();
      idle();
      rst = 1'b0;
      expect_out("rst_err", SEL_ERR, 32'h0);
      drain();

      // All registers read zero after reset.
      for (int a = 0; a < 32; a++) begin
         rd1(5'(a)); rd2(5'(31 - a));
         expect_out($sformatf("init_rd1_%0d", a), SEL_RD1, 32'h0);
         expect_out($sformatf("init_rd2_%0d", a), SEL_RD2, 32'h0);
         expect_out($sformatf("init_stall_%0d", a), SEL_STALL, 32'h0);
         drain();
         cyc();
      end
      idle();

      // Write-first bypass, then array visibility, then r0 stays zero.
      wb(5'd5, 32'h1234_5678, 1'b0); rd1(5'd5);
      expect_out("byp_rd1", SEL_RD1, 32'h1234_5678);
      drain(); cyc(); idle();
      rd1(5'd5);
      expect_out("arr_rd1", SEL_RD1, 32'h1234_5678);
      drain();
      read_en_1 = 1'b0;
      expect_out("rd_disabled", SEL_RD1, 32'h0);
      drain(); idle();
      wb(5'd0, 32'hFFFF_FFFF, 1'b0); rd1(5'd0); rd2(5'd0);
      expect_out("r0_byp_rd1", SEL_RD1, 32'h0);
      expect_out("r0_byp_rd2", SEL_RD2, 32'h0);
      drain(); cyc(); idle();
      rd1(5'd0);
      expect_out("r0_arr_rd1", SEL_RD1, 32'h0);
      drain(); idle();

      // Single load to r8: stall until its write-back, which is bypassed.
      issue_load(5'd8);
      expect_out("ld8_issue_stall", SEL_STALL, 32'h0);
      drain(); cyc(); idle();
      rd2(5'd8);
      expect_out("ld8_stall", SEL_STALL, 32'h1);
      drain(); cyc();
      wb(5'd8, 32'hA5A5_A5A5, 1'b1);
      expect_out("ld8_wb_stall", SEL_STALL, 32'h0);
      expect_out("ld8_wb_rd2", SEL_RD2, 32'hA5A5_A5A5);
      drain(); cyc(); idle();
      rd2(5'd8);
      expect_out("ld8_after_stall", SEL_STALL, 32'h0);
      expect_out("ld8_after_rd2", SEL_RD2, 32'hA5A5_A5A5);
      expect_out("ld8_err", SEL_ERR, 32'h0);
      drain(); idle();

      // Two loads to r9: the first write-back leaves one outstanding.
      issue_load(5'd9); drain(); cyc();
      issue_load(5'd9); drain(); cyc(); idle();
      rd1(5'd9);
      expect_out("ld9_stall2", SEL_STALL, 32'h1);
      drain();
      wb(5'd9, 32'h0000_0001, 1'b1);
      expect_out("ld9_wb1_stall", SEL_STALL, 32'h1);
      drain(); cyc();
      wb(5'd9, 32'h0000_0002, 1'b1);
      expect_out("ld9_wb2_stall", SEL_STALL, 32'h0);
      expect_out("ld9_wb2_rd1", SEL_RD1, 32'h0000_0002);
      drain(); cyc(); idle();
      rd1(5'd9);
      expect_out("ld9_done_stall", SEL_STALL, 32'h0);
      expect_out("ld9_done_rd1", SEL_RD1, 32'h0000_0002);
      drain(); idle();

      // A load issued while stalled must not be counted.
      issue_load(5'd4); drain(); cyc(); idle();
      rd1(5'd4); issue_load(5'd3);
      expect_out("stalled_issue_stall", SEL_STALL, 32'h1);
      drain(); cyc(); idle();
      rd1(5'd3);
      expect_out("r3_no_stall", SEL_STALL, 32'h0);
      drain();
      rd2(5'd4);
      expect_out("r4_still_stall", SEL_STALL, 32'h1);
      drain(); idle();
      wb(5'd4, 32'h4444_4444, 1'b1); drain(); cyc(); idle();

      // Same-register inc+dec nets to zero; different registers update independently.
      issue_load(5'd12); drain(); cyc(); idle();
      issue_load(5'd12); wb(5'd12, 32'hC0C0_C0C0, 1'b1); drain(); cyc(); idle();
      rd1(5'd12);
      expect_out("r12_net_stall", SEL_STALL, 32'h1);
      drain(); idle();
      issue_load(5'd14); wb(5'd12, 32'hC1C1_C1C1, 1'b1); drain(); cyc(); idle();
      rd1(5'd12); rd2(5'd14);
      expect_out("r12r14_stall", SEL_STALL, 32'h1);
      drain();
      read_en_2 = 1'b0;
      expect_out("r12_clear_stall", SEL_STALL, 32'h0);
      expect_out("r12_clear_rd1", SEL_RD1, 32'hC1C1_C1C1);
      drain(); idle();
      wb(5'd14, 32'hE0E0_E0E0, 1'b1); drain(); cyc(); idle();
      expect_out("pre_ovf_err", SEL_ERR, 32'h0);
      drain();

      // Overflow: the fourth load to r7 sets the sticky error.
      for (int k = 0; k < 4; k++) begin
         issue_load(5'd7);
         expect_out($sformatf("ovf_err_before_%0d", k), SEL_ERR, 32'h0);
         drain(); cyc();
      end
      idle();
      expect_out("ovf_err", SEL_ERR, 32'h1);
      drain(); cyc();
      expect_out("ovf_err_sticky", SEL_ERR, 32'h1);
      drain();

      // Reset clears the array, the counters and the error flag.
      rst = 1'b1; cyc(); rst = 1'b0;
      rd1(5'd5); rd2(5'd7);
      expect_out("rst2_err", SEL_ERR, 32'h0);
      expect_out("rst2_rd1", SEL_RD1, 32'h0);
      expect_out("rst2_stall", SEL_STALL, 32'h0);
      drain(); idle();

      // Underflow: a load write-back with nothing pending.
      wb(5'd10, 32'h1010_1010, 1'b1); drain(); cyc(); idle();
      expect_out("unf_err", SEL_ERR, 32'h1);
      drain();
      rst = 1'b1; cyc(); rst = 1'b0;
      expect_out("rst3_err", SEL_ERR, 32'h0);
      drain();

      // Random non-load traffic against a small array model.
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      for (int n = 0; n < 60; n++) begin
         logic [AW-1:0] wa, a1, a2;
         logic [DW-1:0] wd, e1, e2;
         logic          we, e1n, e2n;
         idle();
         we  = 1'($urandom_range(0, 1));
         wa  = 5'($urandom_range(0, 31));
         wd  = $urandom;
         a1  = 5'($urandom_range(0, 31));
         a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         e1n = 1'($urandom_range(0, 3) != 0);
         e2n = 1'($urandom_range(0, 3) != 0);
         if (we) wb(wa, wd, 1'b0);
         read_en_1 = e1n; read_addr_1 = a1;
         read_en_2 = e2n; read_addr_2 = a2;
         e1 = (!e1n || a1 == '0) ? '0 : (we && wa == a1) ? wd : mdl[a1];
         e2 = (!e2n || a2 == '0) ? '0 : (we && wa == a2) ? wd : mdl[a2];
         expect_out($sformatf("rnd_rd1_%0d", n), SEL_RD1, e1);
         expect_out($sformatf("rnd_rd2_%0d", n), SEL_RD2, e2);
         expect_out($sformatf("rnd_stall_%0d", n), SEL_STALL, 32'h0);
         drain();
         if (we && wa != '0) mdl[wa] = wd;
         cyc();
      end
      idle();
      expect_out("rnd_err", SEL_ERR, 32'h0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
